// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low key matrix scanner with frame-based debounce
// Define KEYPAD_REPEAT_EN to add auto-repeat of key_valid while a key stays held.
module keypad_scanner #(
   parameter int SCAN_DIV_W      = 16,
   parameter int DEBOUNCE_FRAMES = 4
`ifdef KEYPAD_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 32,
   parameter int REPEAT_PERIOD   = 8
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic       multi_key
);
   typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

   localparam int         CW = SCAN_DIV_W + 2;
   localparam logic [3:0] DB = 4'(DEBOUNCE_FRAMES);

   state_t        state_q, state_d;
   logic [CW-1:0] scan_cnt_q;
   logic [1:0]    row_idx;
   logic          dwell_end, frame_end;
   logic [3:0]    row_q, sync1_q, sync2_q;
   logic [15:0]   frame_q, frame_d;
   logic [4:0]    key_cnt;
   logic [3:0]    key_idx;
   logic          single, multi, same_key, cand_bit;
   logic [3:0]    cand_q, cand_d, stable_q, stable_d, rel_q, rel_d;
   logic [3:0]    stable_inc, rel_inc;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d, key_held_q, key_held_d;
   logic          multi_key_q, multi_key_d;
`ifdef KEYPAD_REPEAT_EN
   logic [7:0]    rpt_cnt_q, rpt_cnt_d, rpt_inc;
   logic          rpt_phase_q, rpt_phase_d;
`endif

   assign row_idx   = scan_cnt_q[CW-1:SCAN_DIV_W];
   assign dwell_end = &scan_cnt_q[SCAN_DIV_W-1:0];
   assign frame_end = &scan_cnt_q;

   // The frame under evaluation already contains the sample taken this cycle.
   always_comb begin
      frame_d = frame_q;
      if (dwell_end) begin
         frame_d[{row_idx, 2'b00} +: 4] = ~sync2_q;
      end
   end

   always_comb begin
      key_cnt = '0;
      key_idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (frame_d[i]) begin
            key_cnt = key_cnt + 5'd1;
            key_idx = 4'(i);
         end
      end
   end

   assign single     = (key_cnt == 5'd1);
   assign multi      = (key_cnt > 5'd1);
   assign same_key   = single && (key_idx == cand_q);
   assign cand_bit   = frame_d[cand_q];
   assign stable_inc = stable_q + 4'd1;
   assign rel_inc    = rel_q + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt_q <= '0;
         row_q      <= 4'b1111;
         sync1_q    <= 4'b1111;
         sync2_q    <= 4'b1111;
         frame_q    <= '0;
      end else begin
         scan_cnt_q <= scan_cnt_q + 1'b1;
         row_q      <= ~(4'b0001 << row_idx);
         sync1_q    <= col_in;
         sync2_q    <= sync1_q;
         frame_q    <= frame_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (frame_end) begin
         case (state_q)
            S_IDLE:     if (single) state_d = S_DEBOUNCE;
            S_DEBOUNCE: begin
               if (!same_key)               state_d = S_IDLE;
               else if (stable_inc == DB)   state_d = S_PRESSED;
            end
            S_PRESSED:  if (!cand_bit) state_d = S_RELEASE;
            S_RELEASE: begin
               if (cand_bit)                state_d = S_PRESSED;
               else if (rel_inc == DB)      state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      cand_d      = cand_q;
      stable_d    = stable_q;
      rel_d       = rel_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      multi_key_d = multi_key_q;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_d   = rpt_cnt_q;
      rpt_phase_d = rpt_phase_q;
      rpt_inc     = rpt_cnt_q + 8'd1;
      if (state_q != S_PRESSED) begin
         rpt_cnt_d   = '0;
         rpt_phase_d = 1'b0;
      end
`endif
      if (frame_end) begin
         multi_key_d = multi;
         case (state_q)
            S_IDLE: begin
               if (single) begin
                  cand_d   = key_idx;
                  stable_d = 4'd1;
               end
            end
            S_DEBOUNCE: begin
               if (same_key) begin
                  stable_d = stable_inc;
                  if (stable_inc == DB) begin
                     key_code_d  = cand_q;
                     key_valid_d = 1'b1;
                     key_held_d  = 1'b1;
                  end
               end else begin
                  stable_d = 4'd0;
               end
            end
            S_PRESSED: begin
               if (!cand_bit) begin
                  rel_d = 4'd1;
               end
`ifdef KEYPAD_REPEAT_EN
               // First repeat waits REPEAT_DELAY frames, later ones REPEAT_PERIOD.
               if (!cand_bit || multi) begin
                  rpt_cnt_d   = '0;
                  rpt_phase_d = 1'b0;
               end else if (rpt_inc == (rpt_phase_q ? 8'(REPEAT_PERIOD) : 8'(REPEAT_DELAY))) begin
                  key_code_d  = cand_q;
                  key_valid_d = 1'b1;
                  rpt_cnt_d   = '0;
                  rpt_phase_d = 1'b1;
               end else begin
                  rpt_cnt_d   = rpt_inc;
               end
`endif
            end
            S_RELEASE: begin
               if (cand_bit) begin
                  rel_d = 4'd0;
               end else begin
                  rel_d = rel_inc;
                  if (rel_inc == DB) begin
                     key_held_d = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q      <= '0;
         stable_q    <= '0;
         rel_q       <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         multi_key_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rpt_cnt_q   <= '0;
         rpt_phase_q <= 1'b0;
`endif
      end else begin
         cand_q      <= cand_d;
         stable_q    <= stable_d;
         rel_q       <= rel_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         multi_key_q <= multi_key_d;
`ifdef KEYPAD_REPEAT_EN
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_phase_q <= rpt_phase_d;
`endif
      end
   end

   assign row_out   = row_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign multi_key = multi_key_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner (SCAN_DIV_W=2, DEBOUNCE_FRAMES=3)
module tb_keypad_scanner;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  col_in;
   logic [3:0]  row_out, key_code;
   logic        key_valid, key_held, multi_key;
   logic [15:0] keys = '0;

   int          cyc = 0;
   int          pulses = 0;
   int          last_cyc = 0;
   logic [3:0]  last_code = '0;
   int          checks = 0;
   int          failures = 0;
   int          base = 0;

   always #5 clk = ~clk;

   keypad_scanner #(.SCAN_DIV_W(2), .DEBOUNCE_FRAMES(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .col_in    (col_in),
      .row_out   (row_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .multi_key (multi_key)
   );

   // Key matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      col_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         if (!row_out[r]) col_in = col_in & ~keys[r*4 +: 4];
      end
   end

   // cyc = number of clock edges since reset release; pulses logged with the cycle they were high.
   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
      if (rst_n && key_valid) begin
         pulses    <= pulses + 1;
         last_cyc  <= cyc;
         last_code <= key_code;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic do_reset(input logic [15:0] k);
      rst_n = 1'b0;
      keys  = k;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base  = pulses;
   endtask

   initial begin
      logic [3:0] exp_row;

      // Reset values and row sequence
      keys = '0;
      repeat (2) @(negedge clk);
      chk("rst_row_out", 32'(row_out), 32'hF);
      chk("rst_key_code", 32'(key_code), 32'h0);
      chk("rst_key_valid", 32'(key_valid), 32'h0);
      chk("rst_key_held", 32'(key_held), 32'h0);
      chk("rst_multi_key", 32'(multi_key), 32'h0);
      rst_n = 1'b1;
      base  = pulses;
      for (int c = 1; c <= 20; c++) begin
         goto(c);
         exp_row = ~(4'b0001 << (((c - 1) / 4) % 4));
         chk($sformatf("row_seq_c%0d", c), 32'(row_out), 32'(exp_row));
      end
      goto(48);
      chk("idle_no_pulse", 32'(pulses - base), 32'd0);

      // r2c1 held from before frame 1
      do_reset(16'h0200);
      goto(47);
      chk("r2c1_valid_early", 32'(key_valid), 32'h0);
      goto(48);
      chk("r2c1_valid", 32'(key_valid), 32'h1);
      chk("r2c1_code", 32'(key_code), 32'h9);
      chk("r2c1_held", 32'(key_held), 32'h1);
      goto(49);
      chk("r2c1_valid_one_cycle", 32'(key_valid), 32'h0);
      goto(64);
      keys = '0;
      goto(111);
      chk("r2c1_held_before_rel", 32'(key_held), 32'h1);
      goto(112);
      chk("r2c1_held_released", 32'(key_held), 32'h0);
      goto(160);
      chk("r2c1_single_pulse", 32'(pulses - base), 32'd1);
      chk("r2c1_pulse_cycle", 32'(last_cyc), 32'd48);

      // Bounce on r0c3: 1 frame on, 1 off, 2 on, off
      do_reset(16'h0008);
      goto(16);  keys = '0;
      goto(32);  keys = 16'h0008;
      goto(64);  keys = '0;
      goto(112);
      chk("bounce_no_pulse", 32'(pulses - base), 32'd0);
      chk("bounce_held", 32'(key_held), 32'h0);

      // r0c0 + r3c3, then drop r3c3
      do_reset(16'h8001);
      goto(15);
      chk("multi_before_frame", 32'(multi_key), 32'h0);
      goto(16);
      chk("multi_after_frame1", 32'(multi_key), 32'h1);
      goto(48);
      chk("multi_no_pulse", 32'(pulses - base), 32'd0);
      chk("multi_no_held", 32'(key_held), 32'h0);
      keys = 16'h0001;
      goto(63);
      chk("multi_still_set", 32'(multi_key), 32'h1);
      goto(64);
      chk("multi_cleared", 32'(multi_key), 32'h0);
      goto(95);
      chk("r0c0_valid_early", 32'(key_valid), 32'h0);
      goto(96);
      chk("r0c0_valid", 32'(key_valid), 32'h1);
      chk("r0c0_code", 32'(key_code), 32'h0);
      goto(100);
      chk("r0c0_pulse_count", 32'(pulses - base), 32'd1);

      // r1c2: short release is absorbed, full release allows a new press
      do_reset(16'h0040);
      goto(48);
      chk("r1c2_valid", 32'(key_valid), 32'h1);
      chk("r1c2_code", 32'(key_code), 32'h6);
      goto(64);  keys = '0;
      goto(80);
      chk("r1c2_held_in_release", 32'(key_held), 32'h1);
      keys = 16'h0040;
      goto(96);
      chk("r1c2_held_repress", 32'(key_held), 32'h1);
      goto(112);
      chk("r1c2_no_new_pulse", 32'(pulses - base), 32'd1);
      keys = '0;
      goto(159);
      chk("r1c2_held_before_idle", 32'(key_held), 32'h1);
      goto(160);
      chk("r1c2_released", 32'(key_held), 32'h0);
      keys = 16'h0040;
      goto(208);
      chk("r1c2_second_valid", 32'(key_valid), 32'h1);
      goto(212);
      chk("r1c2_second_count", 32'(pulses - base), 32'd2);
      chk("r1c2_second_cycle", 32'(last_cyc), 32'd208);
      chk("r1c2_second_code", 32'(last_code), 32'h6);

      // Asynchronous reset while PRESSED, key held through it
      do_reset(16'h0200);
      goto(56);
      chk("pre_rst_held", 32'(key_held), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("async_row_out", 32'(row_out), 32'hF);
      chk("async_key_code", 32'(key_code), 32'h0);
      chk("async_key_held", 32'(key_held), 32'h0);
      chk("async_multi_key", 32'(multi_key), 32'h0);
      chk("async_key_valid", 32'(key_valid), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base  = pulses;
      goto(47);
      chk("post_rst_valid_early", 32'(key_valid), 32'h0);
      chk("post_rst_held_early", 32'(key_held), 32'h0);
      goto(48);
      chk("post_rst_valid", 32'(key_valid), 32'h1);
      chk("post_rst_code", 32'(key_code), 32'h9);
      goto(60);
      chk("post_rst_count", 32'(pulses - base), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
